// File: rtl/tcl_tx_merge_if.sv
// Purpose: client, link and status signal bundle for tcl_tx_merge (clock/reset stay outside).
// Latency: n/a (wiring only).
// Backpressure: full0..full3 throttle the port clients; pop_out is the link-side read strobe.
// Ports: init/umbral_* (control), push*/data*/full* (per-port write side),
//        pop_out/data_out/empty_out/almost_* (link read side), req/idx/counter_* (counter read), state.
interface tcl_tx_merge_if #(
  parameter int DW = 12
);
  logic          init;
  logic [2:0]    umbral_alto;
  logic [2:0]    umbral_bajo;
  logic          push0, push1, push2, push3;
  logic [DW-1:0] data0, data1, data2, data3;
  logic          full0, full1, full2, full3;
  logic          pop_out;
  logic [DW-1:0] data_out;
  logic          empty_out;
  logic          almost_empty_out;
  logic          almost_full_out;
  logic          req;
  logic [2:0]    idx;
  logic [4:0]    counter_out;
  logic          counter_valid;
  logic [3:0]    state;

  // Driver side (port clients, link and management)
  modport master (
    output init, umbral_alto, umbral_bajo,
    output push0, push1, push2, push3, data0, data1, data2, data3,
    input  full0, full1, full2, full3,
    output pop_out,
    input  data_out, empty_out, almost_empty_out, almost_full_out,
    output req, idx,
    input  counter_out, counter_valid, state
  );

  // Merge block side
  modport slave (
    input  init, umbral_alto, umbral_bajo,
    input  push0, push1, push2, push3, data0, data1, data2, data3,
    output full0, full1, full2, full3,
    input  pop_out,
    output data_out, empty_out, almost_empty_out, almost_full_out,
    input  req, idx,
    output counter_out, counter_valid, state
  );
endinterface

// File: rtl/tcl_tx_merge.sv
// Purpose: merges four per-port 4-deep FIFOs round-robin into one 8-deep link FIFO, tagging bits [11:10] with the port.
// Latency: push at edge N into an idle block -> grant at N+1 -> output FIFO write at N+2.
// Backpressure: grants stop once output occupancy (incl. pipeline word) reaches umbral_alto; full ports drop pushes.
// Ports: clk, reset (async active-low), bus (tcl_tx_merge_if.slave): control/thresholds, 4 write ports,
//        link read port with flags, counter read port, one-hot state.
module tcl_tx_merge #(
  parameter int DW     = 12,
  parameter int IN_AW  = 2,
  parameter int OUT_AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  tcl_tx_merge_if.slave bus
);
  localparam int NP        = 4;
  localparam int NCNT      = 5;
  localparam int IN_DEPTH  = 1 << IN_AW;
  localparam int OUT_DEPTH = 1 << OUT_AW;
  localparam logic [IN_AW:0] IN_FULL = (IN_AW+1)'(IN_DEPTH);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        alto_q, alto_d, bajo_q, bajo_d;
  logic [DW-1:0]     in_mem_q  [NP][IN_DEPTH];
  logic [DW-1:0]     in_mem_d  [NP][IN_DEPTH];
  logic [IN_AW-1:0]  in_wr_q [NP], in_wr_d [NP], in_rd_q [NP], in_rd_d [NP];
  logic [IN_AW:0]    in_cnt_q [NP], in_cnt_d [NP];
  logic              pipe_vld_q, pipe_vld_d;
  logic [DW-1:0]     pipe_dat_q, pipe_dat_d;
  logic [1:0]        rr_q, rr_d;
  logic [DW-1:0]     out_mem_q [OUT_DEPTH];
  logic [DW-1:0]     out_mem_d [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OUT_AW:0]   out_cnt_q, out_cnt_d;
  logic [DW-1:0]     data_out_q, data_out_d;
  logic [4:0]        cnt_q [NCNT], cnt_d [NCNT];
  logic [4:0]        cnt_out_q, cnt_out_d;
  logic              cnt_vld_q, cnt_vld_d;

  logic [NP-1:0]     push_v, in_full, in_nempty, acc, grant;
  logic [DW-1:0]     data_v [NP];
  logic [DW-1:0]     head;
  logic [OUT_AW+1:0] occ;
  logic [1:0]        win, cand;
  logic              found, grant_ok, push_en, pop_ok;
  logic              unused_head_tag;

  assign push_v    = {bus.push3, bus.push2, bus.push1, bus.push0};
  assign data_v[0] = bus.data0;
  assign data_v[1] = bus.data1;
  assign data_v[2] = bus.data2;
  assign data_v[3] = bus.data3;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      in_full[i]   = (in_cnt_q[i] == IN_FULL);
      in_nempty[i] = (in_cnt_q[i] != '0);
    end
  end

  // Round-robin search starts one past the last winner. Occupancy counts the
  // pipeline word so the output FIFO can never be over-committed.
  always_comb begin
    occ      = (OUT_AW+2)'(out_cnt_q) + (OUT_AW+2)'(pipe_vld_q);
    grant_ok = (state_q == ST_ACTIVE) && (|in_nempty) && (occ < (OUT_AW+2)'(alto_q));
    win      = rr_q;
    cand     = rr_q;
    found    = 1'b0;
    for (int k = 1; k <= NP; k++) begin
      cand = rr_q + 2'(k);
      if (!found && in_nempty[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
    grant = '0;
    if (grant_ok) grant[win] = 1'b1;
    head = in_mem_q[win][in_rd_q[win]];
  end

  // The client's own bits [11:10] are replaced by the port tag.
  assign unused_head_tag = ^head[DW-1:DW-2];

  // A full port may still accept when it is popped in the same cycle.
  assign push_en = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign acc     = push_v & {NP{push_en}} & (~in_full | grant);
  assign pop_ok  = bus.pop_out && (out_cnt_q != '0) && (state_q != ST_RESET);

  always_comb begin
    in_mem_d = in_mem_q;
    in_wr_d  = in_wr_q;
    in_rd_d  = in_rd_q;
    in_cnt_d = in_cnt_q;
    for (int i = 0; i < NP; i++) begin
      if (acc[i]) begin
        in_mem_d[i][in_wr_q[i]] = data_v[i];
        in_wr_d[i]              = in_wr_q[i] + 1'b1;
      end
      if (grant[i]) in_rd_d[i] = in_rd_q[i] + 1'b1;
      in_cnt_d[i] = in_cnt_q[i] + (IN_AW+1)'(acc[i]) - (IN_AW+1)'(grant[i]);
    end

    pipe_vld_d = grant_ok;
    pipe_dat_d = pipe_dat_q;
    rr_d       = rr_q;
    if (grant_ok) begin
      pipe_dat_d = {win, head[DW-3:0]};
      rr_d       = win;
    end

    // The pipeline word is always drained, whatever the state, so INIT keeps it.
    out_mem_d  = out_mem_q;
    out_wr_d   = out_wr_q;
    out_rd_d   = out_rd_q;
    data_out_d = data_out_q;
    if (pipe_vld_q) begin
      out_mem_d[out_wr_q] = pipe_dat_q;
      out_wr_d            = out_wr_q + 1'b1;
    end
    if (pop_ok) begin
      data_out_d = out_mem_q[out_rd_q];
      out_rd_d   = out_rd_q + 1'b1;
    end
    out_cnt_d = out_cnt_q + (OUT_AW+1)'(pipe_vld_q) - (OUT_AW+1)'(pop_ok);

    cnt_d = cnt_q;
    if ((state_q == ST_RESET) || (state_q == ST_INIT)) begin
      for (int k = 0; k < NCNT; k++) cnt_d[k] = '0;
    end else begin
      for (int i = 0; i < NP; i++) cnt_d[i] = cnt_q[i] + 5'(acc[i]);
      cnt_d[NP] = cnt_q[NP] + 5'(pop_ok);
    end

    cnt_vld_d = 1'b0;
    cnt_out_d = cnt_out_q;
    if ((state_q == ST_IDLE) && bus.req) begin
      cnt_vld_d = 1'b1;
      case (bus.idx)
        3'd0:    cnt_out_d = cnt_q[0];
        3'd1:    cnt_out_d = cnt_q[1];
        3'd2:    cnt_out_d = cnt_q[2];
        3'd3:    cnt_out_d = cnt_q[3];
        3'd4:    cnt_out_d = cnt_q[4];
        default: cnt_out_d = '0;
      endcase
    end

    alto_d = alto_q;
    bajo_d = bajo_q;
    if (state_q == ST_INIT) begin
      alto_d = bus.umbral_alto;
      bajo_d = bus.umbral_bajo;
    end

    // An accepted push counts as pending work so a word pushed into an idle
    // block is granted on the very next edge.
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (!bus.init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (bus.init)                     state_d = ST_INIT;
        else if ((|in_nempty) || (|acc)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init) state_d = ST_INIT;
        else if (!(|in_nempty) && !(|acc) && !pipe_vld_q && (out_cnt_q == '0))
          state_d = ST_IDLE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      alto_q     <= '0;
      bajo_q     <= '0;
      pipe_vld_q <= 1'b0;
      pipe_dat_q <= '0;
      rr_q       <= 2'd3;
      out_wr_q   <= '0;
      out_rd_q   <= '0;
      out_cnt_q  <= '0;
      data_out_q <= '0;
      cnt_out_q  <= '0;
      cnt_vld_q  <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        in_wr_q[i]  <= '0;
        in_rd_q[i]  <= '0;
        in_cnt_q[i] <= '0;
      end
      for (int k = 0; k < NCNT; k++) cnt_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      alto_q     <= alto_d;
      bajo_q     <= bajo_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_dat_q <= pipe_dat_d;
      rr_q       <= rr_d;
      out_wr_q   <= out_wr_d;
      out_rd_q   <= out_rd_d;
      out_cnt_q  <= out_cnt_d;
      data_out_q <= data_out_d;
      cnt_out_q  <= cnt_out_d;
      cnt_vld_q  <= cnt_vld_d;
      in_wr_q    <= in_wr_d;
      in_rd_q    <= in_rd_d;
      in_cnt_q   <= in_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage arrays need no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    in_mem_q  <= in_mem_d;
    out_mem_q <= out_mem_d;
  end

  assign bus.full0            = in_full[0];
  assign bus.full1            = in_full[1];
  assign bus.full2            = in_full[2];
  assign bus.full3            = in_full[3];
  assign bus.data_out         = data_out_q;
  assign bus.empty_out        = (out_cnt_q == '0);
  assign bus.almost_empty_out = (out_cnt_q <= (OUT_AW+1)'(bajo_q));
  assign bus.almost_full_out  = (out_cnt_q >= (OUT_AW+1)'(alto_q));
  assign bus.counter_out      = cnt_out_q;
  assign bus.counter_valid    = cnt_vld_q;
  assign bus.state            = state_q;
endmodule

// File: tb/tb_tcl_tx_merge.sv
// Purpose: scoreboard bench for tcl_tx_merge; expected link words are queued at stimulus time.
// Latency: n/a.
// Backpressure: the bench drives pop_out explicitly; a monitor checks every accepted pop.
module tb_tcl_tx_merge;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] exp_q [$];
  logic pend = 1'b0;

  tcl_tx_merge_if #(.DW(12)) bus ();

  tcl_tx_merge #(.DW(12), .IN_AW(2), .OUT_AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_push(input int p, input logic v, input logic [11:0] d);
    case (p)
      0: begin bus.push0 = v; bus.data0 = d; end
      1: begin bus.push1 = v; bus.data1 = d; end
      2: begin bus.push2 = v; bus.data2 = d; end
      default: begin bus.push3 = v; bus.data3 = d; end
    endcase
  endtask

  task automatic clr_push();
    for (int p = 0; p < 4; p++) set_push(p, 1'b0, 12'h000);
  endtask

  function automatic logic [11:0] tag(input int p, input logic [11:0] d);
    return {2'(p), d[9:0]};
  endfunction

  // Monitor: a pop accepted at a rising edge shows its word on data_out
  // by the following falling edge.
  always @(negedge clk) begin
    logic [11:0] e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_out: got %0h expected nothing (scoreboard empty)", bus.data_out);
      end else begin
        e = exp_q.pop_front();
        chk("data_out", 32'(bus.data_out), 32'(e));
      end
    end
    pend <= reset && bus.pop_out && !bus.empty_out && (bus.state != 4'b0001);
  end

  task automatic drain(input int maxc);
    bit done = 1'b0;
    bus.pop_out = 1'b1;
    for (int c = 0; c < maxc && !done; c++) begin
      tick(1);
      if (exp_q.size() == 0 && bus.empty_out) done = 1'b1;
    end
    bus.pop_out = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: got %0d words still pending expected 0 after %0d cycles", exp_q.size(), maxc);
    end
  endtask

  task automatic wait_idle(input int maxc);
    bit done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      if (bus.state == 4'b0100) done = 1'b1;
      else tick(1);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle: got state %0h expected 4 within %0d cycles", bus.state, maxc);
    end
  endtask

  task automatic rd_cnt(input logic [2:0] i, input logic [4:0] exp, input string nm);
    bus.req = 1'b1;
    bus.idx = i;
    tick(1);
    bus.req = 1'b0;
    chk({nm, "_vld"}, 32'(bus.counter_valid), 32'd1);
    chk(nm, 32'(bus.counter_out), 32'(exp));
  endtask

  task automatic bring_up(input logic [2:0] a, input logic [2:0] b);
    reset = 1'b0;
    bus.init = 1'b1;
    bus.umbral_alto = a;
    bus.umbral_bajo = b;
    clr_push();
    bus.pop_out = 1'b0;
    bus.req = 1'b0;
    tick(2);
    chk("rst_state", 32'(bus.state), 32'h1);
    chk("rst_data_out", 32'(bus.data_out), 32'h0);
    chk("rst_cnt_vld", 32'(bus.counter_valid), 32'h0);
    chk("rst_empty", 32'(bus.empty_out), 32'h1);
    chk("rst_aempty", 32'(bus.almost_empty_out), 32'h1);
    chk("rst_afull", 32'(bus.almost_full_out), 32'h1);
    chk("rst_full2", 32'(bus.full2), 32'h0);
    reset = 1'b1;
    tick(1);
    chk("state_init1", 32'(bus.state), 32'h2);
    tick(1);
    chk("state_init2", 32'(bus.state), 32'h2);
    bus.init = 1'b0;
    tick(1);
    chk("state_idle", 32'(bus.state), 32'h4);
  endtask

  task automatic reinit(input logic [2:0] a, input logic [2:0] b);
    bus.umbral_alto = a;
    bus.umbral_bajo = b;
    bus.init = 1'b1;
    tick(1);
    chk("reinit_state", 32'(bus.state), 32'h2);
    bus.init = 1'b0;
    tick(1);
    chk("reinit_idle", 32'(bus.state), 32'h4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    logic [11:0] d;
    reset = 1'b1;
    bus.init = 1'b0;
    bus.umbral_alto = 3'd0;
    bus.umbral_bajo = 3'd0;
    bus.pop_out = 1'b0;
    bus.req = 1'b0;
    bus.idx = 3'd0;
    clr_push();
    #2 reset = 1'b0;

    // Bring-up with alto=6 / bajo=1
    bring_up(3'd6, 3'd1);
    chk("idle_empty", 32'(bus.empty_out), 32'h1);
    for (int k = 0; k < 5; k++) rd_cnt(3'(k), 5'd0, "cnt_bringup");

    // Single word on port 2; tag 2'b10 matches the pushed top bits, so 0xABC comes out unchanged
    set_push(2, 1'b1, 12'hABC);
    exp_q.push_back(12'hABC);
    tick(1);
    clr_push();
    chk("lat_n", 32'(bus.empty_out), 32'h1);
    tick(1);
    chk("lat_n1", 32'(bus.empty_out), 32'h1);
    tick(1);
    chk("lat_n2", 32'(bus.empty_out), 32'h0);
    chk("aempty_one", 32'(bus.almost_empty_out), 32'h1);
    drain(20);
    wait_idle(20);
    rd_cnt(3'd2, 5'd1, "cnt2_single");
    rd_cnt(3'd4, 5'd1, "cnt4_single");

    // Reset in the middle of traffic: in-flight words are discarded
    set_push(0, 1'b1, 12'h123);
    set_push(1, 1'b1, 12'h456);
    tick(3);
    clr_push();
    chk("pre_rst_empty", 32'(bus.empty_out), 32'h0);
    reset = 1'b0;
    #1;
    chk("midrst_empty", 32'(bus.empty_out), 32'h1);
    chk("midrst_full1", 32'(bus.full1), 32'h0);
    chk("midrst_state", 32'(bus.state), 32'h1);
    chk("midrst_data_out", 32'(bus.data_out), 32'h0);
    chk("midrst_cnt_out", 32'(bus.counter_out), 32'h0);
    bring_up(3'd6, 3'd1);
    chk("post_rst_empty", 32'(bus.empty_out), 32'h1);
    for (int k = 0; k < 5; k++) rd_cnt(3'(k), 5'd0, "cnt_post_rst");

    // All four ports in one cycle: order 0,1,2,3 with tags 00,01,10,11
    for (int p = 0; p < 4; p++) set_push(p, 1'b1, 12'hFFF);
    exp_q.push_back(12'h3FF);
    exp_q.push_back(12'h7FF);
    exp_q.push_back(12'hBFF);
    exp_q.push_back(12'hFFF);
    tick(1);
    clr_push();
    drain(30);
    wait_idle(20);
    rd_cnt(3'd3, 5'd1, "cnt3_rr");
    rd_cnt(3'd4, 5'd4, "cnt4_rr");

    // alto=4: four grants then stall; ports refill to full; extra pushes dropped
    reinit(3'd4, 3'd1);
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < 4; p++) begin
        d = 12'hC00 | 12'(p * 16) | 12'(k);
        set_push(p, 1'b1, d);
        if (k < 5) exp_q.push_back(tag(p, d));
      end
      tick(1);
    end
    clr_push();
    chk("afull_at4", 32'(bus.almost_full_out), 32'h1);
    chk("full_all", 32'({bus.full3, bus.full2, bus.full1, bus.full0}), 32'hF);
    tick(5);
    chk("full_hold", 32'({bus.full3, bus.full2, bus.full1, bus.full0}), 32'hF);
    chk("afull_hold", 32'(bus.almost_full_out), 32'h1);
    drain(100);
    wait_idle(20);
    for (int p = 0; p < 4; p++) rd_cnt(3'(p), 5'd5, "cnt_port_sat");
    rd_cnt(3'd4, 5'd20, "cnt4_sat");

    // 33 words on port 1 while draining: counter wraps to 1
    reinit(3'd6, 3'd1);
    bus.pop_out = 1'b1;
    for (int k = 0; k < 33; k++) begin
      d = 12'h400 + 12'(k);
      set_push(1, 1'b1, d);
      exp_q.push_back(tag(1, d));
      bus.req = (k == 10);
      bus.idx = 3'd1;
      tick(1);
      if (k == 10) chk("req_active_vld", 32'(bus.counter_valid), 32'h0);
    end
    bus.req = 1'b0;
    clr_push();
    drain(100);
    wait_idle(20);
    rd_cnt(3'd1, 5'd1, "cnt1_wrap");
    rd_cnt(3'd6, 5'd0, "cnt_idx6");
    rd_cnt(3'd4, 5'd1, "cnt4_wrap");
    tick(1);
    chk("cnt_vld_drop", 32'(bus.counter_valid), 32'h0);
    chk("cnt_out_hold", 32'(bus.counter_out), 32'h1);

    // init while ACTIVE with three words queued: counters clear, words kept
    for (int k = 0; k < 3; k++) begin
      d = 12'h0A0 + 12'(k);
      set_push(0, 1'b1, d);
      exp_q.push_back(tag(0, d));
      tick(1);
    end
    clr_push();
    bus.init = 1'b1;
    tick(1);
    chk("init_from_active", 32'(bus.state), 32'h2);
    tick(1);
    bus.init = 1'b0;
    tick(1);
    chk("init_to_idle", 32'(bus.state), 32'h4);
    chk("kept_empty", 32'(bus.empty_out), 32'h0);
    chk("kept_aempty", 32'(bus.almost_empty_out), 32'h0);
    chk("kept_afull", 32'(bus.almost_full_out), 32'h0);
    rd_cnt(3'd0, 5'd0, "cnt0_cleared");
    rd_cnt(3'd4, 5'd0, "cnt4_cleared");
    drain(30);
    rd_cnt(3'd4, 5'd3, "cnt4_after_init");

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
